// File: rtl/sccb_cam_config.sv
// Camera housekeeping pins, power-up reset and SCCB 3-phase register-table writer.
// Optional NACK abort on the 9th bit: define SCCB_NACK_CHECK_EN.
module sccb_cam_config #(
    parameter logic [7:0]  DEV_ADDR       = 8'h42,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned SCCB_QDIV      = 125,
    parameter int unsigned XCLK_DIV       = 2,
    parameter int unsigned POWERUP_CYCLES = 1000,
    parameter int unsigned DELAY_CYCLES   = 500000,
    parameter int unsigned GAP_QUARTERS   = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              sioc,
    output logic              siod_o,
    output logic              siod_oe,
    input  logic              siod_i,
    output logic              xclk,
    output logic              cam_rst_n,
    output logic              pwdn
);

    localparam int unsigned XH = XCLK_DIV / 2;
    localparam int unsigned XW = $clog2(XH + 1);
    localparam int unsigned PW = $clog2(POWERUP_CYCLES + 1);
    localparam int unsigned QW = $clog2(SCCB_QDIV + 1);
    localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_QUARTERS + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS,
        S_STOP, S_GAP, S_DELAY, S_NEXT, S_FINISH
    } state_t;

    state_t        state;
    logic [XW-1:0] xcnt;
    logic [PW-1:0] pu_cnt;
    logic          pu_start;
    logic [QW-1:0] qcnt;
    logic          tick;
    logic          go;
    logic [15:0]   word;
    logic [26:0]   shreg;
    logic [1:0]    qph;
    logic [3:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic          fetch_wait;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] dly_cnt;

    assign pwdn = 1'b0;

    // Free-running camera master clock
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            xcnt <= '0;
            xclk <= 1'b0;
        end else if (xcnt == XW'(XH - 1)) begin
            xcnt <= '0;
            xclk <= ~xclk;
        end else begin
            xcnt <= xcnt + XW'(1);
        end
    end

    // Hold camera in reset after clr, then launch the table once
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pu_cnt    <= '0;
            cam_rst_n <= 1'b0;
            pu_start  <= 1'b0;
        end else begin
            pu_start <= 1'b0;
            if (!cam_rst_n) begin
                if (pu_cnt == PW'(POWERUP_CYCLES - 1)) begin
                    cam_rst_n <= 1'b1;
                    pu_start  <= 1'b1;
                end else begin
                    pu_cnt <= pu_cnt + PW'(1);
                end
            end
        end
    end

    // Quarter-bit tick divider
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            qcnt <= '0;
        end else if (tick) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + QW'(1);
        end
    end

    assign tick = (qcnt == QW'(SCCB_QDIV - 1));
    assign go   = (start & cam_rst_n) | pu_start;

`ifdef SCCB_NACK_CHECK_EN
    logic error_q;
    logic nack;
    assign error = error_q;
`else
    logic unused_siod;
    assign error       = 1'b0;
    assign unused_siod = siod_i;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_IDLE;
            cmd_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sioc       <= 1'b1;
            siod_o     <= 1'b1;
            siod_oe    <= 1'b1;
            word       <= '0;
            shreg      <= '0;
            qph        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            fetch_wait <= 1'b0;
            gap_cnt    <= '0;
            dly_cnt    <= '0;
`ifdef SCCB_NACK_CHECK_EN
            error_q    <= 1'b0;
            nack       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        cmd_addr   <= '0;
                        fetch_wait <= 1'b1;
                        state      <= S_FETCH;
`ifdef SCCB_NACK_CHECK_EN
                        error_q    <= 1'b0;
                        nack       <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else begin
                        word  <= cmd_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    qph <= '0;
                    if (word == 16'hFFFF) begin
                        state <= S_FINISH;
                    end else if (word == 16'hFFF0) begin
                        dly_cnt <= '0;
                        state   <= S_DELAY;
                    end else begin
                        // 9th bit of each byte is a released don't-care, sent as 1
                        shreg <= {DEV_ADDR, 1'b1, word[15:8], 1'b1, word[7:0], 1'b1};
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        qph <= qph + 2'd1;
                        case (qph)
                            2'd0: begin
                                sioc    <= 1'b1;
                                siod_o  <= 1'b1;
                                siod_oe <= 1'b1;
                            end
                            2'd1: siod_o <= 1'b0;
                            default: begin
                                sioc     <= 1'b0;
                                qph      <= '0;
                                bit_idx  <= '0;
                                byte_idx <= '0;
                                state    <= S_BITS;
                            end
                        endcase
                    end
                end
                S_BITS: begin
                    if (tick) begin
                        qph <= qph + 2'd1;
                        case (qph)
                            2'd0: begin
                                sioc    <= 1'b0;
                                siod_o  <= shreg[26];
                                siod_oe <= (bit_idx != 4'd8);
                            end
                            2'd2: begin
                                sioc <= 1'b1;
`ifdef SCCB_NACK_CHECK_EN
                                if (bit_idx == 4'd8 && siod_i) begin
                                    error_q <= 1'b1;
                                    nack    <= 1'b1;
                                    qph     <= '0;
                                    state   <= S_STOP;
                                end
`endif
                            end
                            2'd3: begin
                                shreg <= {shreg[25:0], 1'b0};
                                if (bit_idx == 4'd8) begin
                                    bit_idx  <= '0;
                                    byte_idx <= byte_idx + 2'd1;
                                    if (byte_idx == 2'd2) begin
                                        state <= S_STOP;
                                    end
                                end else begin
                                    bit_idx <= bit_idx + 4'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        qph <= qph + 2'd1;
                        case (qph)
                            2'd0: begin
                                sioc    <= 1'b0;
                                siod_o  <= 1'b0;
                                siod_oe <= 1'b1;
                            end
                            2'd1: sioc <= 1'b1;
                            default: begin
                                siod_o  <= 1'b1;
                                gap_cnt <= '0;
                                state   <= S_GAP;
`ifdef SCCB_NACK_CHECK_EN
                                if (nack) begin
                                    state <= S_FINISH;
                                end
`endif
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GW'(GAP_QUARTERS - 1)) begin
                            state <= S_NEXT;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == DW'(DELAY_CYCLES - 1)) begin
                        state <= S_NEXT;
                    end else begin
                        dly_cnt <= dly_cnt + DW'(1);
                    end
                end
                S_NEXT: begin
                    // Table ends after its last entry rather than wrapping
                    if (&cmd_addr) begin
                        state <= S_FINISH;
                    end else begin
                        cmd_addr   <= cmd_addr + ADDR_W'(1);
                        fetch_wait <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_cam_config.sv
// Scoreboard bench for sccb_cam_config: stimulus pushes expected SCCB bytes/frames,
// a bus monitor decodes sioc/siod and pops/compares.
`timescale 1ns/1ps
module tb_sccb_cam_config;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_data;
    logic          busy, done, error;
    logic          sioc, siod_o, siod_oe;
    logic          siod_i = 1'b0;
    logic          xclk, cam_rst_n, pwdn;

    logic [15:0]   rom [4];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_bytes [$];
    int         exp_nbytes [$];
    int         exp_minidle [$];

    sccb_cam_config #(
        .DEV_ADDR      (8'h42),
        .ADDR_W        (AW),
        .SCCB_QDIV     (2),
        .XCLK_DIV      (4),
        .POWERUP_CYCLES(20),
        .DELAY_CYCLES  (50),
        .GAP_QUARTERS  (4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .sioc     (sioc),
        .siod_o   (siod_o),
        .siod_oe  (siod_oe),
        .siod_i   (siod_i),
        .xclk     (xclk),
        .cam_rst_n(cam_rst_n),
        .pwdn     (pwdn)
    );

    always #5 clk = ~clk;

    // Synchronous table: word valid one cycle after the address
    always_ff @(posedge clk) cmd_data <= rom[cmd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        n_tests++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected >= %0d at %0t", name, act, lim, $time);
        end
    endtask

    task automatic push_frame3(input logic [7:0] r, input logic [7:0] v, input int minidle);
        exp_bytes.push_back(8'h42);
        exp_bytes.push_back(r);
        exp_bytes.push_back(v);
        exp_nbytes.push_back(3);
        exp_minidle.push_back(minidle);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", done, k);
        end
    endtask

    task automatic check_drained();
        check("bytes_left", exp_bytes.size(), 0);
        check("frames_left", exp_nbytes.size(), 0);
    endtask

    // SCCB bus monitor
    logic       p_sioc = 1'b1, p_siod = 1'b1;
    bit         in_frame = 1'b0;
    int         bi = 0, nbytes = 0, idle = 100000, frame_idle = 0, mon_bytes = 0;
    logic [7:0] sh = '0;

    always @(negedge clk) begin
        if (clr) begin
            in_frame = 1'b0;
            bi       = 0;
            idle     = 100000;
        end else begin
            if (idle < 100000) idle++;
            if (p_sioc && sioc && p_siod && !siod_o && siod_oe) begin
                in_frame   = 1'b1;
                bi         = 0;
                nbytes     = 0;
                frame_idle = idle;
            end else if (p_sioc && sioc && !p_siod && siod_o && siod_oe) begin
                if (in_frame) begin
                    if (exp_nbytes.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: %0d bytes seen, none expected", nbytes);
                    end else begin
                        check("frame_bytes", nbytes, exp_nbytes.pop_front());
                        check_ge("frame_idle", frame_idle, exp_minidle.pop_front());
                    end
                end
                in_frame = 1'b0;
                idle     = 0;
            end else if (in_frame && !p_sioc && sioc) begin
                if (bi < 8) begin
                    check("data_oe", siod_oe, 1);
                    sh = {sh[6:0], siod_o};
                    bi++;
                end else begin
                    check("ack_oe", siod_oe, 0);
                    bi = 0;
                    nbytes++;
                    mon_bytes++;
                    if (exp_bytes.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, none expected", sh);
                    end else begin
                        check("sccb_byte", sh, exp_bytes.pop_front());
                    end
                end
            end
        end
        p_sioc = sioc;
        p_siod = siod_o;
    end

    // xclk period monitor
    logic p_xclk = 1'b0;
    int   xc = 0;
    bit   xseen = 1'b0;

    always @(negedge clk) begin
        if (clr) begin
            xseen = 1'b0;
            xc    = 0;
        end else begin
            xc++;
            if (!p_xclk && xclk) begin
                if (xseen) check("xclk_period", xc, 4);
                xseen = 1'b1;
                xc    = 0;
            end
        end
        p_xclk = xclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;

        // Reset state and power-up timing
        rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        repeat (3) @(posedge clk);
        #1;
        check("rst_sioc", sioc, 1);
        check("rst_siod_o", siod_o, 1);
        check("rst_siod_oe", siod_oe, 1);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cam_rst_n", cam_rst_n, 0);
        check("rst_xclk", xclk, 0);
        check("pwdn", pwdn, 0);
        push_frame3(8'h12, 8'h80, 0);
        clr = 1'b0;
        repeat (19) @(posedge clk);
        #1 check("pu_hold", cam_rst_n, 0);
        @(posedge clk); #1;
        check("pu_release", cam_rst_n, 1);
        check("pu_busy_lo", busy, 0);
        @(posedge clk); #1;
        check("pu_busy_hi", busy, 1);
        wait_done(3000);
        check("t0_addr", cmd_addr, 1);
        check("t0_error", error, 0);
        check("t0_busy", busy, 0);
        check_drained();

        // Delay marker between two writes
        rom = '{16'h1104, 16'hFFF0, 16'h1500, 16'hFFFF};
        push_frame3(8'h11, 8'h04, 8);
        push_frame3(8'h15, 8'h00, 58);
        pulse_start();
        wait_done(3000);
        check("t1_addr", cmd_addr, 3);
        check_drained();

        // clr during the second byte aborts and reruns power-up
        rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        exp_bytes.push_back(8'h42);
        base = mon_bytes;
        pulse_start();
        k = 0;
        while (mon_bytes == base && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check("t2_id_byte_seen", mon_bytes - base, 1);
        repeat (20) @(posedge clk);
        #1 check("t2_mid_busy", busy, 1);
        clr = 1'b1;
        #1;
        check("clr_sioc", sioc, 1);
        check("clr_siod_o", siod_o, 1);
        check("clr_siod_oe", siod_oe, 1);
        check("clr_busy", busy, 0);
        check("clr_cam_rst_n", cam_rst_n, 0);
        check("t2_bytes_left", exp_bytes.size(), 0);
        exp_bytes.delete();
        exp_nbytes.delete();
        exp_minidle.delete();
        push_frame3(8'h12, 8'h80, 0);
        @(posedge clk); #1 clr = 1'b0;
        wait_done(3000);
        check("t2_addr", cmd_addr, 1);
        check_drained();

        // start while busy is ignored; start after done restarts from 0
        rom = '{16'h1104, 16'h1500, 16'h1280, 16'hFFFF};
        push_frame3(8'h11, 8'h04, 8);
        push_frame3(8'h15, 8'h00, 8);
        push_frame3(8'h12, 8'h80, 8);
        pulse_start();
        k = 0;
        while (cmd_addr != 2'd1 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("t3_addr_reached", cmd_addr, 1);
        pulse_start();
        check("t3_busy_kept", busy, 1);
        wait_done(3000);
        check("t3_addr", cmd_addr, 3);
        check_drained();
        rom = '{16'h1500, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        push_frame3(8'h15, 8'h00, 8);
        pulse_start();
        check("t3_restart_done", done, 0);
        check("t3_restart_busy", busy, 1);
        check("t3_restart_addr", cmd_addr, 0);
        wait_done(3000);
        check("t3b_addr", cmd_addr, 1);
        check_drained();

        // Table with no end marker stops at the last address
        rom = '{16'h1104, 16'h1280, 16'h1500, 16'h1A5A};
        push_frame3(8'h11, 8'h04, 8);
        push_frame3(8'h12, 8'h80, 8);
        push_frame3(8'h15, 8'h00, 8);
        push_frame3(8'h1A, 8'h5A, 8);
        pulse_start();
        wait_done(4000);
        check("t4_addr", cmd_addr, 3);
        check_drained();

        // siod_i held high on the acknowledge bits
        rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        siod_i = 1'b1;
`ifdef SCCB_NACK_CHECK_EN
        exp_bytes.push_back(8'h42);
        exp_nbytes.push_back(1);
        exp_minidle.push_back(8);
        pulse_start();
        wait_done(3000);
        check("t5_error", error, 1);
        check("t5_addr", cmd_addr, 0);
`else
        push_frame3(8'h12, 8'h80, 8);
        pulse_start();
        wait_done(3000);
        check("t5_error", error, 0);
        check("t5_addr", cmd_addr, 1);
`endif
        check("t5_busy", busy, 0);
        check_drained();
        siod_i = 1'b0;

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
